cpu_out_uart_tx: RTL and testbench



---
 rtl/cpu_out_uart_tx.sv | 169 ++++++++++++++++
 tb/tb_cpu_out_uart_tx.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_out_uart_tx.sv
// rtl/cpu_out_uart_tx.sv - change-triggered byte queue and 8N1 UART transmitter for the CPU output port
//
// Ports:
//   clk           system clock, rising edge
//   ExternalReset asynchronous active-high reset
//   cpu_out       CPU output port value; every change is queued as one byte
//   tx            UART serial line, idle high
//   busy          high while a frame (start, data, stop) is on the line
//   fifo_count    bytes waiting in the queue
//   overflow      sticky: a byte was dropped because the queue was full
module cpu_out_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        ExternalReset,
    input  logic [7:0]                  cpu_out,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [15:0]   BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    sample_q, last_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q;

    state_t        state_q, state_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic push_req, push_ok, pop, full, baud_done;

    assign push_req  = (sample_q != last_q);
    assign full      = (count_q == FULL_CNT);
    // The transmitter only ever pops from IDLE, so a pop can free a slot
    // for a push arriving on the same edge even when the queue is full.
    assign pop       = (state_q == IDLE) && (count_q != '0);
    assign push_ok   = push_req && (!full || pop);
    assign baud_done = (baud_q == BAUD_LAST);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge ExternalReset) begin
        if (ExternalReset) begin
            sample_q   <= 8'h00;
            last_q     <= 8'h00;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            sample_q <= cpu_out;
            if (push_req) begin
                last_q <= sample_q;
            end
            if (push_ok) begin
                wr_q <= wr_q + PW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PW'(1);
            end
            count_q <= count_d;
            if (push_req && !push_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Queue storage needs no reset: count_q gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q] <= sample_q;
        end
    end

    always_ff @(posedge clk or posedge ExternalReset) begin
        if (ExternalReset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // tx is registered: each transition loads the level of the next bit,
    // so the line changes on the same edge the state changes.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                bit_d  = '0;
                if (pop) begin
                    shift_d = mem_q[rd_q];
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_cpu_out_uart_tx.sv
// tb/tb_cpu_out_uart_tx.sv - self-checking bench for cpu_out_uart_tx
module tb_cpu_out_uart_tx;
    localparam int C     = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * C;
    localparam int HMAX  = 16384;

    logic       clk = 1'b0;
    logic       ExternalReset;
    logic [7:0] cpu_out;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;
    logic       overflow;

    cpu_out_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .ExternalReset(ExternalReset),
        .cpu_out      (cpu_out),
        .tx           (tx),
        .busy         (busy),
        .fifo_count   (fifo_count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: a byte queue plus "transmitter free from edge t_free".
    logic [7:0] m_q[$];
    logic [7:0] m_sent[$];
    int         m_start;
    int         t_free;
    logic [7:0] m_byte;
    logic       m_ovf;
    logic [7:0] m_prev;
    logic       m_pend;
    logic [7:0] m_pend_val;
    logic       m_tx;
    logic       m_busy;
    logic [2:0] m_count;

    // Line monitor
    logic tx_hist [HMAX];
    int   obs_starts[$];
    int   obs_end;

    task automatic model_reset();
        m_q.delete();
        m_sent.delete();
        m_start = -1;
        t_free  = 0;
        m_ovf   = 1'b0;
        m_prev  = 8'h00;
        m_pend  = 1'b0;
        m_pend_val = 8'h00;
        m_tx    = 1'b1;
        m_busy  = 1'b0;
        m_count = 3'd0;
        obs_starts.delete();
        obs_end = 0;
    endtask

    // Advance one clock edge, update the model, record tx; returns 1 ns after the edge.
    task automatic step();
        logic [7:0] v;
        int idx;
        v = cpu_out;
        @(posedge clk);
        cyc++;
        if (m_q.size() != 0 && cyc >= t_free) begin
            m_byte = m_q.pop_front();
            m_sent.push_back(m_byte);
            m_start = cyc;
            t_free  = cyc + FRAME + 1;
        end
        if (m_pend) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_pend_val);
            else m_ovf = 1'b1;
        end
        m_pend     = (v != m_prev);
        m_pend_val = v;
        m_prev     = v;
        m_busy = (m_start >= 0) && (cyc >= m_start) && (cyc < m_start + FRAME);
        m_tx   = 1'b1;
        if (m_busy) begin
            idx = (cyc - m_start) / C;
            if (idx == 0) m_tx = 1'b0;
            else if (idx <= 8) m_tx = m_byte[idx-1];
        end
        m_count = 3'(m_q.size());
        #1;
        tx_hist[cyc % HMAX] = tx;
        if (cyc >= obs_end && tx === 1'b0) begin
            obs_starts.push_back(cyc);
            obs_end = cyc + FRAME;
        end
    endtask

    function automatic logic [7:0] decode(int s);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = tx_hist[(s + C * (i + 1) + C / 2) % HMAX];
        return b;
    endfunction

    task automatic do_reset();
        ExternalReset = 1'b1;
        cpu_out = 8'h00;
        model_reset();
        @(posedge clk);
        #1;
        ExternalReset = 1'b0;
    endtask

    task automatic test_reset();
        ExternalReset = 1'b1;
        cpu_out = 8'h00;
        #3;
        checks++;
        if ({tx, busy, fifo_count, overflow} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_async got tx/busy/cnt/ovf=%b/%b/%0d/%b expected 1/0/0/0", tx, busy, fifo_count, overflow);
        end
        @(posedge clk);
        #1;
        ExternalReset = 1'b0;
        model_reset();
        for (int i = 0; i < 200; i++) begin
            step();
            checks++;
            if ({tx, busy, fifo_count, overflow} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d got tx/busy/cnt/ovf=%b/%b/%0d/%b expected 1/0/0/0", i, tx, busy, fifo_count, overflow);
            end
        end
    endtask

    task automatic test_single();
        int c0, fall, busy_cnt;
        logic [9:0] exp_frame;
        logic ok;
        do_reset();
        step();
        step();
        c0 = cyc;
        cpu_out = 8'hA5;
        fall = -1;
        busy_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (busy === 1'b1) busy_cnt++;
            if (fall < 0 && tx === 1'b0) fall = cyc;
        end
        checks++;
        if (fall != c0 + 3) begin
            failures++;
            $display("FAIL single_latency got fall_edge=%0d expected %0d", fall - c0, 3);
        end
        checks++;
        if (busy_cnt != 40) begin
            failures++;
            $display("FAIL single_busy_len got %0d expected 40", busy_cnt);
        end
        if (fall < 0) fall = c0 + 3;
        exp_frame = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 10; k++) begin
            ok = 1'b1;
            for (int j = 0; j < C; j++)
                if (tx_hist[(fall + k * C + j) % HMAX] !== exp_frame[k]) ok = 1'b0;
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL single_bit%0d got %b expected %b held %0d cycles", k, tx_hist[(fall + k * C) % HMAX], exp_frame[k], C);
            end
        end
        checks++;
        if ({tx, busy} !== 2'b10) begin
            failures++;
            $display("FAIL single_after got tx/busy=%b/%b expected 1/0", tx, busy);
        end
    endtask

    task automatic test_back_to_back();
        int peak;
        logic [7:0] exp_b;
        do_reset();
        step();
        step();
        peak = 0;
        for (int i = 1; i <= 3; i++) begin
            cpu_out = 8'(i);
            step();
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        for (int i = 0; i < 140; i++) begin
            step();
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        checks++;
        if (peak != 2) begin
            failures++;
            $display("FAIL b2b_peak got %0d expected 2", peak);
        end
        checks++;
        if (obs_starts.size() != 3) begin
            failures++;
            $display("FAIL b2b_frames got %0d expected 3", obs_starts.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                exp_b = 8'(k + 1);
                checks++;
                if (decode(obs_starts[k]) !== exp_b) begin
                    failures++;
                    $display("FAIL b2b_byte%0d got %h expected %h", k, decode(obs_starts[k]), exp_b);
                end
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_starts[k+1] - obs_starts[k] != FRAME + 1) begin
                    failures++;
                    $display("FAIL b2b_gap%0d got %0d expected %0d", k, obs_starts[k+1] - obs_starts[k], FRAME + 1);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int peak;
        logic [7:0] exp_b;
        do_reset();
        step();
        step();
        peak = 0;
        for (int i = 0; i < 7; i++) begin
            cpu_out = 8'((i + 1) * 17);
            step();
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        for (int i = 0; i < 5 * (FRAME + 1) + 20; i++) begin
            step();
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            if (i == 1) begin
                checks++;
                if (overflow !== 1'b1) begin
                    failures++;
                    $display("FAIL ovf_set got %b expected 1", overflow);
                end
            end
        end
        checks++;
        if (peak != 4) begin
            failures++;
            $display("FAIL ovf_peak got %0d expected 4", peak);
        end
        checks++;
        if (obs_starts.size() != 5) begin
            failures++;
            $display("FAIL ovf_frames got %0d expected 5", obs_starts.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                exp_b = 8'((k + 1) * 17);
                checks++;
                if (decode(obs_starts[k]) !== exp_b) begin
                    failures++;
                    $display("FAIL ovf_byte%0d got %h expected %h", k, decode(obs_starts[k]), exp_b);
                end
            end
        end
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky got %b expected 1", overflow);
        end
    endtask

    task automatic test_full_pop();
        int s;
        logic [7:0] exp_b;
        do_reset();
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            cpu_out = 8'hA1 + 8'(i);
            step();
        end
        s = (obs_starts.size() > 0) ? obs_starts[0] : cyc;
        while (cyc < s + FRAME - 1) step();
        cpu_out = 8'hB6;
        step();
        checks++;
        if (fifo_count !== 3'd4) begin
            failures++;
            $display("FAIL fullpop_before got %0d expected 4", fifo_count);
        end
        step();
        checks++;
        if ({fifo_count, overflow} !== {3'd4, 1'b0}) begin
            failures++;
            $display("FAIL fullpop_edge got cnt/ovf=%0d/%b expected 4/0", fifo_count, overflow);
        end
        for (int i = 0; i < 5 * (FRAME + 1) + 10; i++) step();
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL fullpop_ovf got %b expected 0", overflow);
        end
        checks++;
        if (obs_starts.size() != 6) begin
            failures++;
            $display("FAIL fullpop_frames got %0d expected 6", obs_starts.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                exp_b = (k < 5) ? 8'hA1 + 8'(k) : 8'hB6;
                checks++;
                if (decode(obs_starts[k]) !== exp_b) begin
                    failures++;
                    $display("FAIL fullpop_byte%0d got %h expected %h", k, decode(obs_starts[k]), exp_b);
                end
            end
        end
    endtask

    task automatic test_midreset();
        int s, bad, guard;
        do_reset();
        step();
        cpu_out = 8'h5A;
        step();
        cpu_out = 8'h77;
        step();
        cpu_out = 8'h88;
        guard = 0;
        while (obs_starts.size() == 0 && guard < 20) begin
            step();
            guard++;
        end
        checks++;
        if (obs_starts.size() == 0) begin
            failures++;
            $display("FAIL midrst_start got no frame expected one within 20 cycles");
            s = cyc;
        end else begin
            s = obs_starts[0];
        end
        while (cyc < s + 4 * C + 1) step();
        checks++;
        if ({busy, fifo_count} !== {1'b1, 3'd2}) begin
            failures++;
            $display("FAIL midrst_pre got busy/cnt=%b/%0d expected 1/2", busy, fifo_count);
        end
        #2;
        ExternalReset = 1'b1;
        cpu_out = 8'h00;
        #1;
        checks++;
        if ({tx, busy, fifo_count, overflow} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL midrst_async got tx/busy/cnt/ovf=%b/%b/%0d/%b expected 1/0/0/0", tx, busy, fifo_count, overflow);
        end
        model_reset();
        @(posedge clk);
        #1;
        ExternalReset = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if ({tx, busy, fifo_count} !== {1'b1, 1'b0, 3'd0}) bad++;
        end
        checks++;
        if (bad != 0 || obs_starts.size() != 0) begin
            failures++;
            $display("FAIL midrst_quiet got bad_cycles=%0d frames=%0d expected 0/0", bad, obs_starts.size());
        end
        cpu_out = 8'h3C;
        for (int i = 0; i < FRAME + 10; i++) step();
        checks++;
        if (obs_starts.size() != 1 || decode(obs_starts[0]) !== 8'h3C) begin
            failures++;
            $display("FAIL midrst_resume got frames=%0d expected 1 frame of 3c", obs_starts.size());
        end
    endtask

    task automatic test_random();
        int burst, r;
        do_reset();
        burst = 0;
        for (int i = 0; i < 1200; i++) begin
            if (i < 900) begin
                if (burst > 0) begin
                    cpu_out = 8'($urandom);
                    burst--;
                end else begin
                    r = $urandom_range(0, 99);
                    if (r < 4) burst = $urandom_range(1, 8);
                    else if (r < 10) cpu_out = 8'($urandom);
                end
            end
            step();
            checks++;
            if ({tx, busy, fifo_count, overflow} !== {m_tx, m_busy, m_count, m_ovf}) begin
                failures++;
                $display("FAIL random_cycle i=%0d got tx/busy/cnt/ovf=%b/%b/%0d/%b expected %b/%b/%0d/%b",
                         i, tx, busy, fifo_count, overflow, m_tx, m_busy, m_count, m_ovf);
            end
        end
        checks++;
        if (obs_starts.size() != m_sent.size()) begin
            failures++;
            $display("FAIL random_frames got %0d expected %0d", obs_starts.size(), m_sent.size());
        end else begin
            for (int k = 0; k < m_sent.size(); k++) begin
                checks++;
                if (decode(obs_starts[k]) !== m_sent[k]) begin
                    failures++;
                    $display("FAIL random_byte%0d got %h expected %h", k, decode(obs_starts[k]), m_sent[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_midreset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
